// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and single-digit helpers for the BCD arithmetic
// library (digit-serial multiplier and its sub-blocks).
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } bcd_mul_state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

  // 9x9 digit product split into {tens, ones}; both fields are valid BCD for
  // legal inputs (max 81). Non-BCD inputs give a truncated, meaningless value.
  function automatic logic [7:0] bcd_digit_mul(input bcd_digit_t x, input bcd_digit_t y);
    logic [7:0] p;
    bcd_digit_t tens;
    bcd_digit_t ones;
    p    = 8'(x) * 8'(y);
    tens = 4'(p / 8'd10);
    ones = 4'(p % 8'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_add.sv
// ND-digit packed-BCD ripple adder, carry-in 0, carry-out discarded.
// Callers guarantee the true sum fits in ND digits.
module bcd_add #(
  parameter int ND = 2
) (
  input  logic [ND*4-1:0] x_i,
  input  logic [ND*4-1:0] y_i,
  output logic [ND*4-1:0] s_o
);

  logic [4:0] t_s;
  logic       c_s;

  // Digit-by-digit decimal ripple: a binary digit sum above 9 is corrected by +6.
  always_comb begin
    s_o = '0;
    t_s = 5'd0;
    c_s = 1'b0;
    for (int i = 0; i < ND; i++) begin
      t_s = 5'(x_i[i*4 +: 4]) + 5'(y_i[i*4 +: 4]) + 5'(c_s);
      if (t_s > 5'd9) begin
        s_o[i*4 +: 4] = 4'(t_s + 5'd6);
        c_s           = 1'b1;
      end else begin
        s_o[i*4 +: 4] = t_s[3:0];
        c_s           = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_mul_nx1.sv
// Combinational N-digit x 1-digit packed-BCD multiply giving N+1 digits.
// Each digit product is split into ones/tens; the tens row is shifted up one
// digit and the two rows are summed with the BCD ripple adder.
module bcd_mul_nx1
  import bcd_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N*4-1:0]     a_i,
  input  bcd_digit_t         d_i,
  output logic [(N+1)*4-1:0] p_o
);

  logic [(N+1)*4-1:0] ones_s;
  logic [(N+1)*4-1:0] tens_s;
  logic [7:0]         dp_s;

  // Build the ones row (digits 0..N-1) and tens row (digits 1..N).
  always_comb begin
    ones_s = '0;
    tens_s = '0;
    dp_s   = 8'd0;
    for (int i = 0; i < N; i++) begin
      dp_s                    = bcd_digit_mul(a_i[i*4 +: 4], d_i);
      ones_s[i*4 +: 4]        = dp_s[3:0];
      tens_s[(i+1)*4 +: 4]    = dp_s[7:4];
    end
  end

  bcd_add #(.ND(N+1)) u_row_add (
    .x_i (ones_s),
    .y_i (tens_s),
    .s_o (p_o)
  );

endmodule

// File: rtl/bcd_mul_seq.sv
// Digit-serial N x N packed-BCD multiplier, one multiplier digit per clock,
// 2N-digit product after N cycles.
// Optional build macro BCD_MUL_DIGCHK_EN adds an 'err' output flagging
// non-BCD operand digits captured at start.
module bcd_mul_seq
  import bcd_pkg::*;
#(
  parameter  int N  = 16,
  localparam int CW = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [N*4-1:0] a,
  input  logic [N*4-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [N*8-1:0] o
`ifdef BCD_MUL_DIGCHK_EN
  ,
  output logic           err
`endif
);

  // The accumulator conceptually holds 2N+1 digits. Its top digit is zero after
  // every shift and its bottom digit only settles on the final edge (where it
  // goes straight into o), so only the middle 2N-1 digits are stored.
  bcd_mul_state_t         state_q, state_d;
  logic [N*4-1:0]         ra_q, ra_d;
  logic [N*4-1:0]         rb_q, rb_d;
  logic [(2*N-1)*4-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [N*8-1:0]         o_q, o_d;

  bcd_digit_t             dig_s;
  logic [(N+1)*4-1:0]     pp_s;
  logic [(N+1)*4-1:0]     acc_hi_s;
  logic [(N+1)*4-1:0]     sum_s;
  logic [N*8-1:0]         acc_nxt_s;

`ifdef BCD_MUL_DIGCHK_EN
  logic                   err_q, err_d;
  logic                   bad_s;

  // Flag any non-decimal nibble on either operand at the input pins.
  always_comb begin
    bad_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      bad_s = bad_s | ~is_bcd_digit(a[i*4 +: 4]) | ~is_bcd_digit(b[i*4 +: 4]);
    end
  end
`endif

  // Select the multiplier digit addressed by the step counter.
  always_comb begin
    dig_s = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        dig_s = rb_q[i*4 +: 4];
      end else begin
        dig_s = dig_s;
      end
    end
  end

  bcd_mul_nx1 #(.N(N)) u_pp (
    .a_i (ra_q),
    .d_i (dig_s),
    .p_o (pp_s)
  );

  assign acc_hi_s = {4'd0, acc_q[(2*N-1)*4-1 : (N-1)*4]};

  bcd_add #(.ND(N+1)) u_acc_add (
    .x_i (acc_hi_s),
    .y_i (pp_s),
    .s_o (sum_s)
  );

  // Accumulator after this step's add and one-digit right shift (2N digits).
  assign acc_nxt_s = {sum_s, acc_q[(N-1)*4-1:0]};

  // Next-state logic for the IDLE / MUL / DONE sequencer.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    o_d     = o_q;
`ifdef BCD_MUL_DIGCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (ld) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = MUL;
`ifdef BCD_MUL_DIGCHK_EN
          err_d   = bad_s;
`endif
        end else begin
          state_d = state_q;
        end
      end
      MUL: begin
        acc_d = acc_nxt_s[N*8-1:4];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          o_d     = acc_nxt_s;
        end else begin
          state_d = MUL;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
`ifdef BCD_MUL_DIGCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      o_q     <= o_d;
`ifdef BCD_MUL_DIGCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;
`ifdef BCD_MUL_DIGCHK_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_mul_seq.sv
// Scoreboard bench for bcd_mul_seq: an N=4 and an N=2 instance. Stimulus pushes
// expected product and completion cycle; monitors pop and compare on done rise.
module tb_bcd_mul_seq;

  typedef struct {
    logic [31:0] o;
    int          cyc;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ld, ld2;
  logic [15:0] a, b;
  logic [7:0]  a2, b2;
  logic        busy, done, busy2, done2;
  logic [31:0] o;
  logic [15:0] o2;
`ifdef BCD_MUL_DIGCHK_EN
  logic        err, err2;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t q2[$];

  bcd_mul_seq #(.N(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .a(a), .b(b),
    .busy(busy), .done(done), .o(o)
`ifdef BCD_MUL_DIGCHK_EN
    , .err(err)
`endif
  );

  bcd_mul_seq #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .ld(ld2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .o(o2)
`ifdef BCD_MUL_DIGCHK_EN
    , .err(err2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] exp);
    @(negedge clk);
    a = ta; b = tb; ld = 1'b1;
    @(posedge clk); #1;
    q.push_back('{exp, cyc + 4, 1'b1});
    check("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic issue2(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp);
    @(negedge clk);
    a2 = ta; b2 = tb; ld2 = 1'b1;
    @(posedge clk); #1;
    q2.push_back('{32'(exp), cyc + 2, 1'b1});
    @(negedge clk);
    ld2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL completion_timeout pending=%0d/%0d required=0/0", q.size(), q2.size());
      q.delete();
      q2.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor for the N=4 instance.
  initial begin : mon1
    exp_t e;
    logic dp;
    dp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1 && dp !== 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done cycle=%0d with no pending operation", cyc);
        end else begin
          e = q.pop_front();
          if (e.chk) check("product", o, e.o);
          check("latency", cyc, e.cyc);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      dp = done;
    end
  end

  // Monitor for the N=2 instance.
  initial begin : mon2
    exp_t e;
    logic dp;
    dp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done2 === 1'b1 && dp !== 1'b1) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done_n2 cycle=%0d with no pending operation", cyc);
        end else begin
          e = q2.pop_front();
          check("product_n2", 32'(o2), e.o);
          check("latency_n2", cyc, e.cyc);
          check("busy_at_done_n2", 32'(busy2), 32'd0);
        end
      end
      dp = done2;
    end
  end

  // Directed stimulus sequence.
  initial begin : stim
    rst = 1'b1; ld = 1'b0; ld2 = 1'b0;
    a = 16'h0; b = 16'h0; a2 = 8'h0; b2 = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_o", o, 32'd0);
    check("reset_o_n2", 32'(o2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h5678, 32'h07006652);
    wait_idle();
    issue(16'h9999, 16'h9999, 32'h99980001);
    wait_idle();
    issue(16'h0000, 16'h4321, 32'h00000000);
    wait_idle();
    issue(16'h0001, 16'h0001, 32'h00000001);
    wait_idle();

    // ld while busy must be ignored
    issue(16'h1234, 16'h5678, 32'h07006652);
    @(posedge clk);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    wait_idle();

    // reset in the middle of an operation aborts it
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_o", o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    issue(16'h0025, 16'h0018, 32'h00000450);
    wait_idle();

    // ld held high: one product every N+1 cycles
    @(negedge clk);
    a = 16'h0002; b = 16'h0003; ld = 1'b1;
    @(posedge clk); #1;
    q.push_back('{32'h00000006, cyc + 4, 1'b1});
    q.push_back('{32'h00000006, cyc + 9, 1'b1});
    q.push_back('{32'h00000006, cyc + 14, 1'b1});
    repeat (14) @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    wait_idle();

    // N=2 boundary
    issue2(8'h99, 8'h99, 16'h9801);
    wait_idle();
    issue2(8'h12, 8'h34, 16'h0408);
    wait_idle();

`ifdef BCD_MUL_DIGCHK_EN
    @(negedge clk);
    a = 16'h12A4; b = 16'h0001; ld = 1'b1;
    @(posedge clk); #1;
    q.push_back('{32'h0, cyc + 4, 1'b0});
    check("err_set", 32'(err), 32'd1);
    @(negedge clk);
    ld = 1'b0;
    wait_idle();
    issue(16'h0003, 16'h0003, 32'h00000009);
    check("err_clear", 32'(err), 32'd0);
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
